load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 261 ++++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Bridges a core-side load/store request port to a simple data-memory bus.
// Requests are issued to the bus combinationally in the same cycle they are
// presented. Loads carry a small tag (funct3 + byte offset) through an
// in-order FIFO so that the returning bus word can be lane-selected and
// sign/zero-extended when it comes back. Stores are fire-and-forget.
//
// Parameters
//   MAX_OUTSTANDING  loads issued to the bus and not yet answered (1..8)
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (consumed when both high)
//   req_store             1 = store, 0 = load
//   req_funct3            RV32I width/sign code (B, H, W, BU, HU)
//   req_address           byte address
//   req_write_data        store data, right-justified
//   resp_valid/resp_data  registered load result, one-cycle pulse
//   access_error          registered pulse for a consumed illegal request
//   protocol_error        sticky: bus_valid arrived with nothing outstanding
//   bus_address           word-aligned request address
//   bus_write_data        store data replicated onto every lane
//   bus_byte_enable       active lanes, zero when the bus is idle
//   bus_read_enable       load issued to the bus
//   bus_write_enable      store issued to the bus
//   bus_wait_req          bus back-pressure
//   bus_valid             load data valid (in issue order)
//   bus_read_data         load data word
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,

    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        access_error,
    output logic        protocol_error,

    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    output logic        bus_read_enable,
    output logic        bus_write_enable,
    input  logic        bus_wait_req,
    input  logic        bus_valid,
    input  logic [31:0] bus_read_data
);

    // Pointer width is kept at least one bit so a depth-1 FIFO still has a
    // legal (constant zero) pointer.
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    // RV32I load/store width codes.
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Everything needed to format a load once its data returns.
    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] offset;
    } tag_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    tag_t             tag_mem_q [MAX_OUTSTANDING];
    tag_t             tag_mem_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic             access_error_q, access_error_d;
    logic             protocol_error_q, protocol_error_d;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic        funct3_ok;
    logic        aligned;
    logic        legal;
    logic        has_room;
    logic [3:0]  lane_mask;
    logic [31:0] lane_data;
    logic        consume;
    logic        push;
    logic        pop;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case statements leaves it unassigned (no latch).
    always_comb begin
        funct3_ok = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: funct3_ok = 1'b1;
            F3_BU, F3_HU:     funct3_ok = !req_store;  // unsigned forms are load-only
            default:          funct3_ok = 1'b0;
        endcase

        // funct3[1:0] encodes the access size independent of signedness.
        aligned = 1'b0;
        case (req_funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = !req_address[0];
            2'b10:   aligned = (req_address[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase

        lane_mask = 4'b1111;
        lane_data = req_write_data;
        case (req_funct3[1:0])
            2'b00: begin
                lane_mask = 4'b0001 << req_address[1:0];
                lane_data = {4{req_write_data[7:0]}};
            end
            2'b01: begin
                lane_mask = 4'b0011 << req_address[1:0];
                lane_data = {2{req_write_data[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                lane_data = req_write_data;
            end
        endcase
    end

    assign legal    = funct3_ok && aligned;
    // The stall decision uses the registered count only: a pop landing in
    // the same cycle as a full-FIFO load does not let that load through.
    assign has_room = (count_q < DEPTH);

    // -----------------------------------------------------------------------
    // Combinational issue path
    // -----------------------------------------------------------------------
    always_comb begin
        bus_address      = {req_address[31:2], 2'b00};
        bus_write_data   = lane_data;
        bus_read_enable  = req_valid && !req_store && legal && has_room;
        bus_write_enable = req_valid &&  req_store && legal;
        bus_byte_enable  = (bus_read_enable || bus_write_enable) ? lane_mask : 4'b0000;

        // Illegal requests are swallowed immediately and only flagged via
        // access_error; they never wait on the bus.
        if (!legal) begin
            req_ready = 1'b1;
        end else begin
            req_ready = !bus_wait_req && (req_store || has_room);
        end
    end

    assign consume = req_valid && req_ready;
    assign push    = consume && !req_store && legal;
    assign pop     = bus_valid && (count_q != '0);

    // -----------------------------------------------------------------------
    // Load data formatting for the FIFO head
    // -----------------------------------------------------------------------
    tag_t        head;
    logic [31:0] shifted;
    logic [31:0] load_result;

    always_comb begin
        head    = tag_mem_q[rd_ptr_q];
        // Bring the addressed byte/halfword down to bit 0.
        shifted = bus_read_data >> {head.offset, 3'b000};
        case (head.funct3)
            F3_B:    load_result = {{24{shifted[7]}},  shifted[7:0]};
            F3_H:    load_result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_result = {24'd0, shifted[7:0]};
            F3_HU:   load_result = {16'd0, shifted[15:0]};
            default: load_result = shifted;  // word: offset is always zero
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        tag_mem_d        = tag_mem_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        resp_valid_d     = pop;
        resp_data_d      = pop ? load_result : resp_data_q;
        access_error_d   = consume && !legal;
        protocol_error_d = protocol_error_q || (bus_valid && (count_q == '0));

        if (push) begin
            tag_mem_d[wr_ptr_q] = '{funct3: req_funct3, offset: req_address[1:0]};
            wr_ptr_d            = next_ptr(wr_ptr_q);
        end

        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            resp_valid_q     <= 1'b0;
            resp_data_q      <= '0;
            access_error_q   <= 1'b0;
            protocol_error_q <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            resp_valid_q     <= resp_valid_d;
            resp_data_q      <= resp_data_d;
            access_error_q   <= access_error_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    // NOTE: tag storage is deliberately left out of reset; an entry is only
    // read after it has been written, because count gates every pop.
    always_ff @(posedge clock) begin
        tag_mem_q <= tag_mem_d;
    end

    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign access_error   = access_error_q;
    assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed scenarios followed by a randomized run. A reference model holds
// outstanding loads in a queue and derives lanes, legality and load results
// from access size and byte offset with plain arithmetic. Inputs are applied
// on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int MAX_OUT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        access_error;
    logic        protocol_error;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic        bus_wait_req;
    logic        bus_valid;
    logic [31:0] bus_read_data;

    always #5 clock = ~clock;

    load_store_unit #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_store        (req_store),
        .req_funct3       (req_funct3),
        .req_address      (req_address),
        .req_write_data   (req_write_data),
        .resp_valid       (resp_valid),
        .resp_data        (resp_data),
        .access_error     (access_error),
        .protocol_error   (protocol_error),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_byte_enable  (bus_byte_enable),
        .bus_read_enable  (bus_read_enable),
        .bus_write_enable (bus_write_enable),
        .bus_wait_req     (bus_wait_req),
        .bus_valid        (bus_valid),
        .bus_read_data    (bus_read_data)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] f3;
        logic [1:0] off;
    } pend_t;

    pend_t       pend[$];
    logic        exp_resp_valid;
    logic [31:0] exp_resp_data;
    logic        exp_access;
    logic        exp_proto;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit known;
        known = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return known && ((int'(a[1:0]) % acc_size(f3)) == 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be;
        int off;
        int sz;
        be  = 4'b0000;
        off = int'(a[1:0]);
        sz  = acc_size(f3);
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + sz) be[i] = 1'b1;
        end
        return be;
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int sz;
        sz = acc_size(f3);
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = wd[8*(i % sz) +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
        longint val;
        longint span;
        int sz;
        sz = acc_size(f3);
        if (sz == 4) return d;
        span = longint'(1) << (8 * sz);
        val  = longint'(d >> (8 * int'(off))) % span;
        if (f3[2] == 1'b0 && val >= span / 2) val = val - span;
        return val[31:0];
    endfunction

    // One clock cycle: apply inputs, check the registered outputs produced by
    // the previous cycle and the combinational outputs for these inputs, then
    // advance the model as the coming rising edge will.
    task automatic step(input bit v, input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit wt, input bit bv, input logic [31:0] rd);
        bit    legal;
        bit    full;
        bit    ready_e;
        bit    re_e;
        bit    we_e;
        pend_t h;
        @(negedge clock);
        req_valid      = v;
        req_store      = st;
        req_funct3     = f3;
        req_address    = a;
        req_write_data = wd;
        bus_wait_req   = wt;
        bus_valid      = bv;
        bus_read_data  = rd;
        #1;
        check("resp_valid", 32'(resp_valid), 32'(exp_resp_valid));
        if (exp_resp_valid) check("resp_data", resp_data, exp_resp_data);
        check("access_error", 32'(access_error), 32'(exp_access));
        check("protocol_error", 32'(protocol_error), 32'(exp_proto));

        legal   = model_legal(st, f3, a);
        full    = pend.size() >= MAX_OUT;
        ready_e = !legal ? 1'b1 : (!wt && (st || !full));
        re_e    = v && !st && legal && !full;
        we_e    = v && st && legal;
        check("req_ready", 32'(req_ready), 32'(ready_e));
        check("bus_read_enable", 32'(bus_read_enable), 32'(re_e));
        check("bus_write_enable", 32'(bus_write_enable), 32'(we_e));
        check("bus_address", bus_address, a & 32'hFFFF_FFFC);
        check("bus_byte_enable", 32'(bus_byte_enable), (re_e || we_e) ? 32'(model_be(f3, a)) : 32'd0);
        if (we_e) check("bus_write_data", bus_write_data, model_wd(f3, wd));

        exp_resp_valid = 1'b0;
        if (bv && pend.size() > 0) begin
            h              = pend.pop_front();
            exp_resp_valid = 1'b1;
            exp_resp_data  = model_load(h.f3, h.off, rd);
        end else if (bv) begin
            exp_proto = 1'b1;
        end
        exp_access = v && ready_e && !legal;
        if (v && ready_e && !st && legal) pend.push_back('{f3, a[1:0]});
    endtask

    task automatic idle(input bit bv, input logic [31:0] rd);
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, bv, rd);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset        = 1'b1;
        req_valid    = 1'b0;
        bus_valid    = 1'b0;
        bus_wait_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        pend.delete();
        exp_resp_valid = 1'b0;
        exp_resp_data  = 32'd0;
        exp_access     = 1'b0;
        exp_proto      = 1'b0;
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_access_error", 32'(access_error), 32'd0);
        check("rst_protocol_error", 32'(protocol_error), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        req_valid      = 1'b0;
        req_store      = 1'b0;
        req_funct3     = 3'd0;
        req_address    = 32'd0;
        req_write_data = 32'd0;
        bus_wait_req   = 1'b0;
        bus_valid      = 1'b0;
        bus_read_data  = 32'd0;
        do_reset();

        // LB 0x1003, data back one cycle later, sign-extended byte 3.
        step(1, 0, 3'd0, 32'h0000_1003, 32'd0, 0, 0, 32'd0);
        check("lb_be", 32'(bus_byte_enable), 32'h8);
        check("lb_re", 32'(bus_read_enable), 32'd1);
        idle(1, 32'h80FF_FF00);
        idle(0, 32'd0);
        check("lb_resp_valid", 32'(resp_valid), 32'd1);
        check("lb_resp_data", resp_data, 32'hFFFF_FF80);

        // SH 0x2002.
        step(1, 1, 3'd1, 32'h0000_2002, 32'h0000_ABCD, 0, 0, 32'd0);
        check("sh_we", 32'(bus_write_enable), 32'd1);
        check("sh_be", 32'(bus_byte_enable), 32'hC);
        check("sh_wd", bus_write_data, 32'hABCD_ABCD);
        check("sh_addr", bus_address, 32'h0000_2000);
        idle(0, 32'd0);
        check("sh_no_resp", 32'(resp_valid), 32'd0);

        // Misaligned LW 0x3001.
        step(1, 0, 3'd2, 32'h0000_3001, 32'd0, 0, 0, 32'd0);
        check("lw_mis_re", 32'(bus_read_enable), 32'd0);
        check("lw_mis_we", 32'(bus_write_enable), 32'd0);
        check("lw_mis_ready", 32'(req_ready), 32'd1);
        idle(0, 32'd0);
        check("lw_mis_access_error", 32'(access_error), 32'd1);

        // Three back-to-back LBU, bus latency 3, FIFO depth 2.
        step(1, 0, 3'd4, 32'h0000_4000, 32'd0, 0, 0, 32'd0);
        step(1, 0, 3'd4, 32'h0000_4001, 32'd0, 0, 0, 32'd0);
        step(1, 0, 3'd4, 32'h0000_4002, 32'd0, 0, 0, 32'd0);
        check("lbu3_stall", 32'(req_ready), 32'd0);
        step(1, 0, 3'd4, 32'h0000_4002, 32'd0, 0, 1, 32'h1122_3344);
        check("lbu3_stall_on_pop", 32'(req_ready), 32'd0);
        step(1, 0, 3'd4, 32'h0000_4002, 32'd0, 0, 1, 32'h5566_7788);
        check("lbu3_accept", 32'(req_ready), 32'd1);
        check("lbu_resp0", resp_data, 32'h0000_0044);
        idle(0, 32'd0);
        check("lbu_resp1", resp_data, 32'h0000_0077);
        idle(0, 32'd0);
        idle(1, 32'h99AA_BBCC);
        idle(0, 32'd0);
        check("lbu_resp2_valid", 32'(resp_valid), 32'd1);
        check("lbu_resp2", resp_data, 32'h0000_00AA);

        // Wait request holds off a load.
        step(1, 0, 3'd2, 32'h0000_5000, 32'd0, 1, 0, 32'd0);
        check("wait_ready", 32'(req_ready), 32'd0);
        step(1, 0, 3'd2, 32'h0000_5000, 32'd0, 0, 0, 32'd0);
        check("wait_release", 32'(req_ready), 32'd1);
        idle(1, 32'hCAFE_F00D);
        idle(0, 32'd0);
        check("wait_resp", resp_data, 32'hCAFE_F00D);

        // Reset with two loads outstanding, then a stray bus_valid.
        step(1, 0, 3'd2, 32'h0000_6000, 32'd0, 0, 0, 32'd0);
        step(1, 0, 3'd2, 32'h0000_6004, 32'd0, 0, 0, 32'd0);
        do_reset();
        idle(1, 32'h1234_5678);
        idle(0, 32'd0);
        check("rst_stray_resp", 32'(resp_valid), 32'd0);
        check("rst_stray_protocol", 32'(protocol_error), 32'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 2) == 0,
                     3'($urandom_range(0, 7)),
                     $urandom,
                     $urandom,
                     $urandom_range(0, 3) == 0,
                     (pend.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0),
                     $urandom);
            end
        end
        idle(0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
